// File: rtl/sar_frontend_model.sv
// Behavioural front end for a SAR ADC: sample-and-hold, a pipelined comparator
// and conversion bookkeeping. It checks every result the SAR controller reports
// against the value that was held while the conversion ran.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | no conversion in progress; waiting for sample_i
// ST_TRACK| hold register follows vin_i while sample_i is high
// ST_HOLD | hold register frozen; SAR search running until eoc_i or abort
`timescale 1ns/1ps

module sar_frontend_model #(
   parameter int Width  = 6,
   parameter int CmpLat = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] vin_i,
   input  logic             sample_i,
   input  logic [Width-1:0] dac_i,
   input  logic             eoc_i,
   input  logic [Width-1:0] result_i,
   output logic             cmp_o,
   output logic [Width-1:0] hold_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [7:0]       conv_cnt_o,
   output logic [7:0]       err_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [Width-1:0]   hold_q, hold_d;
   logic [CmpLat-1:0]  cmp_pipe_q, cmp_pipe_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [7:0]         conv_cnt_q, conv_cnt_d;
   logic [7:0]         err_cnt_q, err_cnt_d;
   logic               accept;
   logic               cmp_raw;
   logic               mismatch;

   // Next state; an abort (sample_i in HOLD) wins over a simultaneous eoc_i.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sample_i) state_d = ST_TRACK;
         end
         ST_TRACK: begin
            if (!sample_i) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (sample_i) begin
               state_d = ST_TRACK;
            end else if (eoc_i) begin
               state_d = ST_IDLE;
               accept  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The hold register tracks vin_i whenever sampling is requested, so on the
   // edge that leaves TRACK it keeps the last value seen with sample_i high.
   always_comb begin
      hold_d = hold_q;
      if (sample_i) hold_d = vin_i;
   end

   // Comparator: unsigned hold >= dac, then CmpLat register stages.
   assign cmp_raw = (hold_q >= dac_i);

   always_comb begin
      cmp_pipe_d    = cmp_pipe_q;
      cmp_pipe_d[0] = cmp_raw;
      for (int i = 1; i < CmpLat; i++) begin
         cmp_pipe_d[i] = cmp_pipe_q[i-1];
      end
   end

   // Result check and saturating counters, updated only on an accepted eoc_i.
   assign mismatch = (result_i != hold_q);

   always_comb begin
      done_d     = accept;
      err_d      = err_q;
      conv_cnt_d = conv_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (accept) begin
         err_d = mismatch;
         if (conv_cnt_q != 8'hFF) conv_cnt_d = conv_cnt_q + 8'd1;
         if (mismatch && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // All state; reset discards any conversion in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         hold_q     <= '0;
         cmp_pipe_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         conv_cnt_q <= 8'd0;
         err_cnt_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         cmp_pipe_q <= cmp_pipe_d;
         done_q     <= done_d;
         err_q      <= err_d;
         conv_cnt_q <= conv_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign cmp_o      = cmp_pipe_q[CmpLat-1];
   assign hold_o     = hold_q;
   assign busy_o     = (state_q == ST_HOLD);
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign conv_cnt_o = conv_cnt_q;
   assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_sar_frontend_model.sv
// Bench for sar_frontend_model: a CmpLat=1 instance carries the conversion
// scenarios, a CmpLat=3 instance on the same inputs checks comparator latency.
`timescale 1ns/1ps

module tb_sar_frontend_model;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [5:0] vin_i = '0;
   logic       sample_i = 1'b0;
   logic [5:0] dac_i = '0;
   logic       eoc_i = 1'b0;
   logic [5:0] result_i = '0;

   logic       cmp_o, busy_o, done_o, err_o;
   logic [5:0] hold_o;
   logic [7:0] conv_cnt_o, err_cnt_o;

   logic       cmp3_o, busy3_o, done3_o, err3_o;
   logic [5:0] hold3_o;
   logic [7:0] conv_cnt3_o, err_cnt3_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       err;
      logic [7:0] conv;
      logic [7:0] errc;
   } exp_t;

   exp_t exp_q[$];
   logic cmp1_q[$];
   logic cmp3_q[$];

   logic       m_err = 1'b0;
   logic [7:0] m_conv = '0;
   logic [7:0] m_errc = '0;
   logic [5:0] m_hold = '0;

   always #5 clk_i = ~clk_i;

   sar_frontend_model #(.Width(6), .CmpLat(1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .vin_i(vin_i), .sample_i(sample_i),
      .dac_i(dac_i), .eoc_i(eoc_i), .result_i(result_i),
      .cmp_o(cmp_o), .hold_o(hold_o), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o), .conv_cnt_o(conv_cnt_o), .err_cnt_o(err_cnt_o)
   );

   sar_frontend_model #(.Width(6), .CmpLat(3)) dut3 (
      .clk_i(clk_i), .rst_ni(rst_ni), .vin_i(vin_i), .sample_i(sample_i),
      .dac_i(dac_i), .eoc_i(eoc_i), .result_i(result_i),
      .cmp_o(cmp3_o), .hold_o(hold3_o), .busy_o(busy3_o), .done_o(done3_o),
      .err_o(err3_o), .conv_cnt_o(conv_cnt3_o), .err_cnt_o(err_cnt3_o)
   );

   task automatic cyc();
      @(negedge clk_i);
   endtask

   task automatic enter_hold(input logic [5:0] v, input int ncyc);
      vin_i    = v;
      sample_i = 1'b1;
      for (int i = 0; i < ncyc; i++) cyc();
      sample_i = 1'b0;
      m_hold   = v;
      cyc();
      checks++;
      if (busy_o !== 1'b1 || hold_o !== v) begin
         errors++;
         $display("FAIL hold_entry: busy=%0b hold=%0d, want busy=1 hold=%0d", busy_o, hold_o, v);
      end
   endtask

   task automatic finish_conv(input logic [5:0] r);
      exp_t e;
      m_err = (r != m_hold);
      if (m_conv != 8'hFF) m_conv++;
      if (m_err && m_errc != 8'hFF) m_errc++;
      e.err = m_err; e.conv = m_conv; e.errc = m_errc;
      exp_q.push_back(e);
      result_i = r;
      eoc_i    = 1'b1;
      cyc();
      eoc_i    = 1'b0;
      checks++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse: done=%0b, want 1", done_o);
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         if (err_o !== e.err || conv_cnt_o !== e.conv || err_cnt_o !== e.errc || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL accept: err=%0b conv=%0d errc=%0d busy=%0b, want err=%0b conv=%0d errc=%0d busy=0",
                     err_o, conv_cnt_o, err_cnt_o, busy_o, e.err, e.conv, e.errc);
         end
      end
      cyc();
      checks++;
      if (done_o !== 1'b0) begin
         errors++;
         $display("FAIL done_width: done=%0b, want 0", done_o);
      end
   endtask

   task automatic check_idle_flags(input string name);
      checks++;
      if (done_o !== 1'b0 || err_o !== m_err || conv_cnt_o !== m_conv || err_cnt_o !== m_errc) begin
         errors++;
         $display("FAIL %s: done=%0b err=%0b conv=%0d errc=%0d, want done=0 err=%0b conv=%0d errc=%0d",
                  name, done_o, err_o, conv_cnt_o, err_cnt_o, m_err, m_conv, m_errc);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      cyc(); cyc();
      checks++;
      if ({cmp_o, hold_o, busy_o, done_o, err_o, conv_cnt_o, err_cnt_o, cmp3_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: cmp=%0b hold=%0d busy=%0b done=%0b err=%0b conv=%0d errc=%0d cmp3=%0b, want all 0",
                  cmp_o, hold_o, busy_o, done_o, err_o, conv_cnt_o, err_cnt_o, cmp3_o);
      end
      rst_ni = 1'b1;
      cyc();
      check_idle_flags("reset_release");
   endtask

   task automatic test_convert();
      logic [5:0] dacs [6] = '{6'd32, 6'd48, 6'd40, 6'd36, 6'd38, 6'd37};
      logic       got;
      enter_hold(6'd37, 3);
      for (int i = 0; i < 6; i++) begin
         dac_i = dacs[i];
         cmp1_q.push_back(m_hold >= dacs[i]);
         cyc();
         got = cmp1_q.pop_front();
         checks++;
         if (cmp_o !== got) begin
            errors++;
            $display("FAIL cmp_search[%0d]: dac=%0d cmp=%0b, want %0b", i, dacs[i], cmp_o, got);
         end
      end
      finish_conv(6'd37);
   endtask

   task automatic test_mismatch();
      enter_hold(6'd20, 2);
      finish_conv(6'd21);
      enter_hold(6'd63, 2);
      finish_conv(6'd63);
   endtask

   task automatic test_abort();
      enter_hold(6'd12, 2);
      sample_i = 1'b1;
      eoc_i    = 1'b1;
      result_i = 6'd12;
      cyc();
      eoc_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: busy=%0b, want 0", busy_o);
      end
      check_idle_flags("abort_flags");
      cyc();
      check_idle_flags("abort_after");
      enter_hold(6'd9, 2);
      finish_conv(6'd9);
   endtask

   task automatic test_eoc_ignored();
      eoc_i    = 1'b1;
      result_i = 6'd55;
      cyc();
      check_idle_flags("eoc_idle");
      sample_i = 1'b1;
      vin_i    = 6'd3;
      cyc(); cyc();
      check_idle_flags("eoc_track");
      eoc_i    = 1'b0;
      sample_i = 1'b0;
      cyc();
      m_hold = 6'd3;
      finish_conv(6'd3);
   endtask

   task automatic test_saturate();
      logic [5:0] v;
      for (int n = 0; n < 300; n++) begin
         v = 6'($urandom_range(63));
         enter_hold(v, 1);
         finish_conv(v);
      end
      checks++;
      if (conv_cnt_o !== 8'd255) begin
         errors++;
         $display("FAIL conv_saturate: conv=%0d, want 255", conv_cnt_o);
      end
      eoc_i = 1'b1;
      cyc();
      eoc_i = 1'b0;
      check_idle_flags("eoc_idle_sat");
   endtask

   task automatic test_latency();
      logic [5:0] seq [12] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd63, 6'd63,
                               6'd63, 6'd63, 6'd10, 6'd9, 6'd11, 6'd0};
      logic got;
      enter_hold(6'd10, 2);
      cmp3_q.delete();
      for (int i = 0; i < 12; i++) begin
         dac_i = seq[i];
         cmp1_q.push_back(m_hold >= seq[i]);
         cmp3_q.push_back(m_hold >= seq[i]);
         cyc();
         got = cmp1_q.pop_front();
         checks++;
         if (cmp_o !== got) begin
            errors++;
            $display("FAIL cmp_lat1[%0d]: cmp=%0b, want %0b", i, cmp_o, got);
         end
         if (cmp3_q.size() == 3) begin
            got = cmp3_q.pop_front();
            checks++;
            if (cmp3_o !== got) begin
               errors++;
               $display("FAIL cmp_lat3[%0d]: cmp=%0b, want %0b", i, cmp3_o, got);
            end
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      checks++;
      if (busy_o !== 1'b1 || conv_cnt_o === 8'd0) begin
         errors++;
         $display("FAIL pre_reset: busy=%0b conv=%0d, want busy=1 conv>0", busy_o, conv_cnt_o);
      end
      @(posedge clk_i);
      #3 rst_ni = 1'b0;
      #1;
      checks++;
      if ({cmp_o, hold_o, busy_o, done_o, err_o, conv_cnt_o, err_cnt_o, cmp3_o, hold3_o} !== '0) begin
         errors++;
         $display("FAIL async_reset: cmp=%0b hold=%0d busy=%0b done=%0b err=%0b conv=%0d errc=%0d cmp3=%0b, want all 0",
                  cmp_o, hold_o, busy_o, done_o, err_o, conv_cnt_o, err_cnt_o, cmp3_o);
      end
      m_err = 1'b0; m_conv = '0; m_errc = '0;
      eoc_i = 1'b1;
      cyc();
      rst_ni = 1'b1;
      cyc();
      eoc_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_state: busy=%0b, want 0", busy_o);
      end
      check_idle_flags("post_reset_flags");
   endtask

   initial begin
      test_reset();
      test_convert();
      test_mismatch();
      test_abort();
      test_eoc_ignored();
      test_saturate();
      test_latency();
      test_reset_mid_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sar_frontend_model.md
SAR_FRONTEND_MODEL -- requirements
Module: sar_frontend_model

Interface
REQ-001 Parameter Width, default 6: conversion width in bits, legal range 2..10.
REQ-002 Parameter CmpLat, default 1: comparator latency in clock cycles, legal range 1..4.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous assert, active-low (already decided); deassertion synchronous to clk_i.
REQ-005 vin_i  input  Width  digital stand-in for the analog input level.
REQ-006 sample_i  input  1  sample request from the SAR controller; high = track.
REQ-007 dac_i  input  Width  DAC code driven by the SAR controller.
REQ-008 eoc_i  input  1  end-of-conversion strobe from the SAR controller.
REQ-009 result_i  input  Width  conversion result from the SAR controller, valid when eoc_i=1.
REQ-010 cmp_o  output  1  comparator decision returned to the SAR controller.
REQ-011 hold_o  output  Width  current sample-and-hold value.
REQ-012 busy_o  output  1  high while in HOLD state.
REQ-013 done_o  output  1  one-cycle pulse on accepted end of conversion.
REQ-014 err_o  output  1  mismatch flag of the last accepted conversion.
REQ-015 conv_cnt_o  output  8  accepted-conversion counter.
REQ-016 err_cnt_o  output  8  mismatching-conversion counter.

Function
REQ-017 FSM states: IDLE, TRACK, HOLD.
REQ-018 IDLE: sample_i=1 -> TRACK; otherwise stay.
REQ-019 TRACK: hold register loads vin_i every cycle; sample_i=0 -> HOLD, with the hold register keeping the vin_i value captured on the last cycle sample_i was high.
REQ-020 HOLD: hold register frozen; eoc_i=1 -> IDLE, with the conversion accepted on that edge.
REQ-021 HOLD with sample_i=1: abort the conversion, go to TRACK, no counter change, no done_o; this takes priority over a simultaneous eoc_i.
REQ-022 eoc_i in IDLE or TRACK: ignored; no state, flag or counter change.
REQ-023 Raw comparison: raw = 1 when hold >= dac_i (unsigned), else 0; equality yields 1.
REQ-024 cmp_o is raw delayed through exactly CmpLat register stages: the dac_i value presented at edge n is reflected on cmp_o after edge n+CmpLat-1.
REQ-025 The comparator pipeline runs in all states; its output outside HOLD is don't-care for the controller, but it must still follow the REQ-024 timing.
REQ-026 On acceptance: done_o=1 for exactly one cycle, the cycle after the accepting edge.
REQ-027 On acceptance: err_o is set to (result_i != hold) and holds that value until the next acceptance.
REQ-028 On acceptance: conv_cnt_o increments; err_cnt_o increments if there is a mismatch.
REQ-029 Both counters saturate at 255 and do not wrap.
REQ-030 busy_o = (state == HOLD), registered state decode with no extra latency.
REQ-031 A new TRACK entry does not clear err_o or the counters.

Reset
REQ-032 While rst_ni=0: state IDLE, hold register 0, all comparator pipeline stages 0.
REQ-033 While rst_ni=0: cmp_o=0, hold_o=0, busy_o=0, done_o=0, err_o=0, conv_cnt_o=0, err_cnt_o=0.
REQ-034 Reset in TRACK or HOLD discards the conversion with no counter update and no done_o pulse.

Verification
REQ-035 Width=6, CmpLat=1; vin_i=37, sample_i high 3 cycles then low; ideal SAR controller drives dac_i 32,48,40,36,38,37 -> cmp_o 1,0,0,1,0,1; eoc_i with result_i=37 -> done_o pulse, err_o=0, conv_cnt_o=1, err_cnt_o=0.
REQ-036 hold=20; eoc_i with result_i=21 -> err_o=1, err_cnt_o=1; next conversion with hold=63, result_i=63 -> err_o=0, err_cnt_o stays 1, conv_cnt_o=2.
REQ-037 In HOLD, sample_i=1 and eoc_i=1 in the same cycle -> TRACK, no done_o, counters unchanged.
REQ-038 CmpLat=3; dac_i steps 0->63 with hold=10 -> cmp_o falls exactly 3 cycles after the step edge.
REQ-039 300 matching conversions -> conv_cnt_o saturates at 255; eoc_i while in IDLE -> no change.
REQ-040 rst_ni pulled low mid-HOLD, asynchronous to clk_i -> all outputs 0 immediately; state IDLE after release.
